// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares a single ALU/compare datapath between two requesters. Round-robin
// arbitration in IDLE, operands latched at accept, result returned on one
// tagged valid/ready response channel.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   r0_* / r1_*               requester channels (valid/ready, op, a, b, tag)
//   rsp_valid/rsp_ready       response handshake
//   rsp_id, rsp_tag, rsp_data owner index, echoed tag, result
//
// Build option: define ALU_ARB_FASTPATH_EN to drop the EXEC state. The result
// is then computed from the request and registered at accept, which gives one
// cycle less latency and one op every 2 cycles.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [2:0]        r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [TAG_W-1:0]  r0_tag,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [2:0]        r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [TAG_W-1:0]  r1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nx;
  logic   last_grant;   // 1: r1 was granted last, so r0 wins the next tie
  logic   sel1, accept;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_a, req_b;
  logic [TAG_W-1:0]  req_tag;

`ifndef ALU_ARB_FASTPATH_EN
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
`endif

  // Signed compares use a true signed comparison rather than the sign of
  // A-B, so operand pairs whose difference overflows still compare exactly.
  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = {{(DATA_W-1){1'b0}}, ($signed(a) > $signed(b))};
      3'b011:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b100:  r = {{(DATA_W-1){1'b0}}, (a > b)};
      3'b101:  r = {{(DATA_W-1){1'b0}}, (a < b)};
      3'b110:  r = a & b;
      3'b111:  r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // r1 is picked when it is the only one asking, or on a tie after r0 went last.
  always_comb begin
    sel1     = r1_valid && (!r0_valid || !last_grant);
    r0_ready = !rst && (state == IDLE) && r0_valid && !sel1;
    r1_ready = !rst && (state == IDLE) && sel1;
    accept   = r0_ready || r1_ready;
    req_op   = sel1 ? r1_op  : r0_op;
    req_a    = sel1 ? r1_a   : r0_a;
    req_b    = sel1 ? r1_b   : r0_b;
    req_tag  = sel1 ? r1_tag : r0_tag;
  end

  always_comb begin
    state_nx = state;
    case (state)
`ifdef ALU_ARB_FASTPATH_EN
      IDLE:    if (accept) state_nx = RESP;
`else
      IDLE:    if (accept) state_nx = EXEC;
`endif
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_data   <= '0;
`ifndef ALU_ARB_FASTPATH_EN
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= sel1;
        rsp_id     <= sel1;
        rsp_tag    <= req_tag;
`ifdef ALU_ARB_FASTPATH_EN
        rsp_data   <= alu(req_op, req_a, req_b);
`else
        op_q       <= req_op;
        a_q        <= req_a;
        b_q        <= req_b;
`endif
      end
`ifndef ALU_ARB_FASTPATH_EN
      if (state == EXEC) rsp_data <= alu(op_q, a_q, b_q);
`endif
    end
  end

endmodule
